// File: rtl/register_file_pkg.sv
// register_file_pkg
// Shared types and default sizing for the general-purpose register file.
//   rf_state_t   : sequencer state (clear sweep / ready)
//   DEF_*        : default parameter values used by register_file and rf_read_port
//   rf_depth()   : number of registers for a given address width
package register_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int DEF_DEPTH = rf_depth(DEF_ADDR_W);

endpackage

// File: rtl/register_file_read_port.sv
// rf_read_port
// One registered read port of the register file: zero-register / bypass /
// array select followed by the RDATA/RVALID output flops.
//   CLK, RST   : clock, asynchronous active-high reset
//   ready_st   : sequencer is in ST_READY (reads are served)
//   re, raddr  : read enable and address for this port
//   we_ok      : a write is being accepted on this edge
//   waddr      : write address  (for bypass match)
//   wdata      : write data     (bypass source)
//   mem_data   : array[raddr] before this edge
//   rdata      : registered read data
//   rvalid     : registered read-data valid
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ready_st,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we_ok,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    // Highest register index is all ones in the address field.
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '1;

    logic [DATA_W-1:0] sel_data;

    // Zero register takes priority over bypass, bypass over the array.
    always_comb begin
        sel_data = mem_data;
        if ((ZERO_REG != 0) && (raddr == ZERO_ADDR)) begin
            sel_data = '0;
        end else if ((BYPASS != 0) && we_ok && (waddr == raddr)) begin
            sel_data = wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (!ready_st) begin
            // Reads during the clear sweep return an invalid zero.
            rvalid <= 1'b0;
            if (re) begin
                rdata <= '0;
            end
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= sel_data;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// register_file
// Multi-port register file with registered reads, write-to-read bypass,
// hard-wired zero register and a hardware clear sequencer.
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset
//   RE     : per-port read enable            [NUM_RD]
//   RADDR  : read addresses, port p at [p*ADDR_W +: ADDR_W]
//   RDATA  : registered read data, port p at [p*DATA_W +: DATA_W]
//   RVALID : per-port read-data valid        [NUM_RD]
//   WE, WADDR, WDATA : write port
//   CLR    : request a full clear sweep
//   READY  : array initialised and accepting writes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweeping zeros through the array, one register per cycle
// ST_READY | normal operation: writes accepted, reads served
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD-1:0]        RE,
    input  logic [NUM_RD*ADDR_W-1:0] RADDR,
    output logic [NUM_RD*DATA_W-1:0] RDATA,
    output logic [NUM_RD-1:0]        RVALID,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WADDR,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic                     CLR,
    output logic                     READY
);

    localparam int DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    rf_state_t         state;
    logic [ADDR_W-1:0] idx;
    logic              ready_st;
    logic              we_ok;

    assign ready_st = (state == ST_READY);

    // CLR wins over a same-edge write; the zero register never stores.
    assign we_ok = ready_st && WE && !CLR &&
                   !((ZERO_REG != 0) && (WADDR == LAST_IDX));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_CLEAR;
            idx   <= '0;
            READY <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (CLR) begin
                        idx <= '0;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_READY;
                        READY <= 1'b1;
                        idx   <= '0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (CLR) begin
                        state <= ST_CLEAR;
                        READY <= 1'b0;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    READY <= 1'b0;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Array has no reset; the sweep is what initialises it.
    always_ff @(posedge CLK) begin
        if (!ready_st) begin
            mem[idx] <= '0;
        end else if (we_ok) begin
            mem[WADDR] <= WDATA;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [DATA_W-1:0] mem_q;
        assign mem_q = mem[RADDR[p*ADDR_W +: ADDR_W]];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .CLK      (CLK),
            .RST      (RST),
            .ready_st (ready_st),
            .re       (RE[p]),
            .raddr    (RADDR[p*ADDR_W +: ADDR_W]),
            .we_ok    (we_ok),
            .waddr    (WADDR),
            .wdata    (WDATA),
            .mem_data (mem_q),
            .rdata    (RDATA[p*DATA_W +: DATA_W]),
            .rvalid   (RVALID[p])
        );
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
// Two instances share stimulus: dut_b1 (BYPASS=1) and dut_b0 (BYPASS=0).
// Reads push hand-computed expectations per instance/port; a monitor pops
// and compares whenever RVALID is seen.
module tb_register_file;

    logic         CLK = 1'b0;
    logic         RST;
    logic [1:0]   RE;
    logic [9:0]   RADDR;
    logic         WE;
    logic [4:0]   WADDR;
    logic [63:0]  WDATA;
    logic         CLR;

    logic [127:0] rdata1, rdata0;
    logic [1:0]   rvalid1, rvalid0;
    logic         ready1, ready0;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q1p0[$], q1p1[$], q0p0[$], q0p1[$];

    localparam logic [63:0] V5 = 64'hDEAD_BEEF_0000_0001;

    always #5 CLK = ~CLK;

    register_file #(.BYPASS(1)) dut_b1 (
        .CLK(CLK), .RST(RST), .RE(RE), .RADDR(RADDR), .RDATA(rdata1),
        .RVALID(rvalid1), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .CLR(CLR), .READY(ready1)
    );

    register_file #(.BYPASS(0)) dut_b0 (
        .CLK(CLK), .RST(RST), .RE(RE), .RADDR(RADDR), .RDATA(rdata0),
        .RVALID(rvalid0), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .CLR(CLR), .READY(ready0)
    );

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RE  = 2'b00;
        WE  = 1'b0;
        CLR = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        WE    = 1'b1;
        WADDR = a;
        WDATA = d;
    endtask

    // Issue a read on one port; e1/e0 are the expected data for the
    // bypassing and non-bypassing instance respectively.
    task automatic rd(input int port, input logic [4:0] a,
                      input logic [63:0] e1, input logic [63:0] e0);
        RE[port] = 1'b1;
        if (port == 0) begin
            RADDR[4:0] = a;
            q1p0.push_back(e1);
            q0p0.push_back(e0);
        end else begin
            RADDR[9:5] = a;
            q1p1.push_back(e1);
            q0p1.push_back(e0);
        end
    endtask

    // Clear sweep: 32 edges with reads enabled; READY rises after the last.
    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            RE    = 2'b11;
            RADDR = {5'(i), 5'(31 - i)};
            tick();
            chk({tag, " ready_b1"}, 64'(ready1), 64'(i == 31));
            chk({tag, " ready_b0"}, 64'(ready0), 64'(i == 31));
            chk({tag, " rvalid_b1"}, 64'(rvalid1), 64'd0);
            chk({tag, " rvalid_b0"}, 64'(rvalid0), 64'd0);
            chk({tag, " rdata_b1"}, rdata1[63:0] | rdata1[127:64], 64'd0);
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        RADDR = '0;
        WADDR = '0;
        WDATA = '0;
        idle();

        fork
            forever begin
                @(negedge CLK);
                if (rvalid1[0]) begin
                    if (q1p0.size() == 0) chk("b1p0 unexpected rvalid", 64'(rvalid1[0]), 64'd0);
                    else chk("b1p0 rdata", rdata1[63:0], q1p0.pop_front());
                end
                if (rvalid1[1]) begin
                    if (q1p1.size() == 0) chk("b1p1 unexpected rvalid", 64'(rvalid1[1]), 64'd0);
                    else chk("b1p1 rdata", rdata1[127:64], q1p1.pop_front());
                end
                if (rvalid0[0]) begin
                    if (q0p0.size() == 0) chk("b0p0 unexpected rvalid", 64'(rvalid0[0]), 64'd0);
                    else chk("b0p0 rdata", rdata0[63:0], q0p0.pop_front());
                end
                if (rvalid0[1]) begin
                    if (q0p1.size() == 0) chk("b0p1 unexpected rvalid", 64'(rvalid0[1]), 64'd0);
                    else chk("b0p1 rdata", rdata0[127:64], q0p1.pop_front());
                end
            end
        join_none

        // Reset state
        tick(); tick(); tick();
        chk("rst ready", 64'(ready1), 64'd0);
        chk("rst rvalid", 64'(rvalid1), 64'd0);
        chk("rst rdata", rdata1[63:0], 64'd0);
        RST = 1'b0;
        sweep("reset sweep");
        rd(0, 5'd9, 64'd0, 64'd0);
        rd(1, 5'd30, 64'd0, 64'd0);
        tick(); idle();

        // Write then read on both ports
        wr(5'd5, V5);
        tick(); idle();
        rd(0, 5'd5, V5, V5);
        rd(1, 5'd5, V5, V5);
        tick(); idle();
        tick();
        chk("hold rvalid", 64'(rvalid1), 64'd0);
        chk("hold rdata p0", rdata1[63:0], V5);
        chk("hold rdata p1", rdata1[127:64], V5);

        // Bypass
        wr(5'd7, 64'hAAAA);
        tick(); idle();
        wr(5'd7, 64'h1234);
        rd(0, 5'd7, 64'h1234, 64'hAAAA);
        tick(); idle();
        rd(1, 5'd7, 64'h1234, 64'h1234);
        tick(); idle();

        // Zero register, plain and bypass
        wr(5'd31, 64'hFFFF);
        tick(); idle();
        rd(0, 5'd31, 64'd0, 64'd0);
        tick(); idle();
        wr(5'd31, 64'hFFFF);
        rd(1, 5'd31, 64'd0, 64'd0);
        rd(0, 5'd5, V5, V5);
        tick(); idle();

        // Independent addresses
        rd(0, 5'd7, 64'h1234, 64'h1234);
        rd(1, 5'd5, V5, V5);
        tick(); idle();

        // CLR vs WE
        for (int i = 0; i < 4; i++) begin
            wr(5'(i), 64'h10 + 64'(i));
            tick();
        end
        idle();
        rd(0, 5'd2, 64'h12, 64'h12);
        rd(1, 5'd3, 64'h13, 64'h13);
        tick(); idle();
        CLR = 1'b1;
        wr(5'd2, 64'h99);
        tick(); idle();
        chk("clr ready_b1", 64'(ready1), 64'd0);
        chk("clr ready_b0", 64'(ready0), 64'd0);
        sweep("clr sweep");
        rd(0, 5'd2, 64'd0, 64'd0);
        rd(1, 5'd0, 64'd0, 64'd0);
        tick(); idle();
        rd(0, 5'd3, 64'd0, 64'd0);
        rd(1, 5'd7, 64'd0, 64'd0);
        tick(); idle();

        // Reset mid-sweep at index 10
        wr(5'd4, 64'h44);
        tick(); idle();
        CLR = 1'b1;
        tick(); idle();
        for (int i = 0; i < 10; i++) tick();
        RST = 1'b1;
        #1;
        chk("midrst ready", 64'(ready1), 64'd0);
        tick(); tick();
        RST = 1'b0;
        sweep("midrst sweep");
        rd(0, 5'd4, 64'd0, 64'd0);
        rd(1, 5'd5, 64'd0, 64'd0);
        tick(); idle();

        tick(); tick(); tick();
        chk("responses outstanding",
            64'(q1p0.size() + q1p1.size() + q0p0.size() + q0p1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
